// File: rtl/loader_pkg.sv
// Shared types and constants for the user-code loader.
// States, word geometry and bus constants.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WR_REQ,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_GAP,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [3:0]  BYTE_SEL_ALL   = 4'hF;
    localparam logic [31:0] ADDR_STEP      = 32'd4;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// word_valid_o flags the byte that completes a word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // Shift each new byte in from the top so byte 0 ends in [7:0].
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {byte_i, word_q[31:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = word_q;

endmodule

// File: rtl/user_code_loader.sv
// Bus initiator filling the user-code BRAM from a byte stream.
// Optional readback check of each word: define LOADER_VERIFY_EN.
module user_code_loader
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ce,
    output logic             we_in,
    output logic [31:0]      addr,
    output logic [31:0]      wr_data,
    output logic [3:0]       byte_sel,
    input  logic [31:0]      rd_data,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_e    state_q;
    logic             ce_q;
    logic             we_q;
    logic             s_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [31:0]      addr_q;
    logic [3:0]       bsel_q;
    logic [CNT_W-1:0] wd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TW-1:0]    tmo_q;

    logic             xfer;
    logic             pk_clear;
    logic             word_valid;
    logic [31:0]      pk_word;
    logic             tmo_hit;

    assign xfer     = s_valid && s_ready_q;
    assign pk_clear = (state_q == ST_IDLE) && start;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pk_clear),
        .byte_i       (s_data),
        .byte_valid_i (xfer),
        .word_o       (pk_word),
        .word_valid_o (word_valid)
    );

`ifndef LOADER_VERIFY_EN
    logic unused_rd;
    assign unused_rd = ^rd_data;
`endif

    // Load sequencer: collect a word, write it, gap, repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= 32'd0;
            bsel_q    <= 4'd0;
            wd_q      <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr & ~32'd3;
                        cnt_q   <= word_count;
                        wd_q    <= '0;
                        error_q <= 1'b0;
                        bsel_q  <= BYTE_SEL_ALL;
                        if (word_count == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            done_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_valid) begin
                        s_ready_q <= 1'b0;
                        ce_q      <= 1'b1;
                        we_q      <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (ready) begin
                        ce_q    <= 1'b0;
                        state_q <= ST_WR_GAP;
`ifndef LOADER_VERIFY_EN
                        wd_q    <= wd_q + CNT_W'(1);
                        addr_q  <= addr_q + ADDR_STEP;
`endif
                    end else if (tmo_hit) begin
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
`ifdef LOADER_VERIFY_EN
                ST_WR_GAP: begin
                    ce_q    <= 1'b1;
                    we_q    <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (ready && (rd_data == pk_word)) begin
                        ce_q    <= 1'b0;
                        wd_q    <= wd_q + CNT_W'(1);
                        addr_q  <= addr_q + ADDR_STEP;
                        state_q <= ST_RD_GAP;
                    end else if (ready || tmo_hit) begin
                        ce_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_RD_GAP: begin
`else
                ST_WR_GAP: begin
`endif
                    if (wd_q == cnt_q) begin
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        s_ready_q <= 1'b1;
                        state_q   <= ST_COLLECT;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign ce         = ce_q;
    assign we_in      = we_q;
    assign addr       = addr_q;
    assign wr_data    = pk_word;
    assign byte_sel   = bsel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = wd_q;

endmodule
